// File: rtl/rom_upload.sv
// Serves hps_io upload byte reads from SDRAM on the ce_ref slot, using the download page map.
// A one-byte tagged buffer holds the last fetched byte, refilled by a next-address prefetch.
module rom_upload #(
   parameter int DATA_SLOTS = 1,
   parameter int PREFETCH   = 1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_ref,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   input  logic [8:0]  page,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic        mem_rd,
   output logic [22:0] mem_a,
   output logic [1:0]  mem_bank,
   input  logic [7:0]  mem_dout
);

   localparam logic [7:0] LAST_SLOT = 8'(DATA_SLOTS - 1);
   localparam logic       PF_EN     = (PREFETCH != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } state_t;

   // Returns {mem_a, mem_bank} for a byte address under the download page map.
   function automatic logic [24:0] map_addr(input logic [24:0] addr, input logic [7:0] idx,
                                            input logic [8:0] pg);
      logic [8:0] base;
      logic [1:0] bank;
      logic [7:0] pb;
      pb = pg[7:0] + addr[21:14];
      if (idx == 8'h00) begin
         case (addr[15:14])
            2'd0:    base = 9'h000;
            2'd1:    base = 9'h100;
            2'd2:    base = 9'h107;
            2'd3:    base = 9'h1FF;
            default: base = 9'h000;
         endcase
         bank = {1'b0, addr[16]};
      end else begin
         base = {pg[8], pb};
         bank = {1'b0, &idx[7:6]};
      end
      return {base, addr[13:0], bank};
   endfunction

   function automatic logic addr_oor(input logic [24:0] addr, input logic [7:0] idx);
      logic oor;
      if (idx == 8'h00) begin
         oor = (addr[24:17] != 8'h00);
      end else begin
         oor = (addr[24:22] != 3'b000);
      end
      return oor;
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic [24:0] fa_r, fa_s;
   logic [7:0]  fi_r, fi_s;
   logic [24:0] tgt_addr_r, tgt_addr_s;
   logic [7:0]  tgt_idx_r, tgt_idx_s;
   logic        tgt_v_r, tgt_v_s;
   logic        pend_r, pend_s;
   logic [24:0] buf_tag_r, buf_tag_s;
   logic [7:0]  buf_idx_r, buf_idx_s;
   logic [7:0]  buf_dat_r, buf_dat_s;
   logic        buf_v_r, buf_v_s;
   logic [7:0]  din_r, din_s;
   logic        wait_r, wait_s;
   logic [22:0] mem_a_r, mem_a_s;
   logic [1:0]  mem_bank_r, mem_bank_s;

   logic        pf_go_s;
   logic [24:0] pf_addr_s;
   logic [7:0]  pf_idx_s;
   logic        pf_oor_s;
   logic [24:0] tgt_map_s;
   logic        req_oor_s;
   logic        hit_s;
   logic        rd_act_s;

   assign tgt_map_s = map_addr(tgt_addr_r, tgt_idx_r, page);
   assign req_oor_s = addr_oor(ioctl_addr, ioctl_index);
   assign rd_act_s  = ioctl_rd & ioctl_upload;
   assign hit_s     = buf_v_r & (buf_tag_r == ioctl_addr) & (buf_idx_r == ioctl_index);

   assign ioctl_din  = din_r;
   assign ioctl_wait = wait_r;
   assign mem_a      = mem_a_r;
   assign mem_bank   = mem_bank_r;
   // The read strobe must coincide with the slot, so it cannot be registered.
   assign mem_rd     = (state_r == ISSUE) & ce_ref & ioctl_upload;

   // Next-state, fetch target, buffer and output-register logic.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      fa_s       = fa_r;
      fi_s       = fi_r;
      tgt_addr_s = tgt_addr_r;
      tgt_idx_s  = tgt_idx_r;
      tgt_v_s    = tgt_v_r;
      pend_s     = pend_r;
      buf_tag_s  = buf_tag_r;
      buf_idx_s  = buf_idx_r;
      buf_dat_s  = buf_dat_r;
      buf_v_s    = buf_v_r;
      din_s      = din_r;
      wait_s     = wait_r;
      mem_a_s    = mem_a_r;
      mem_bank_s = mem_bank_r;
      pf_go_s    = 1'b0;
      pf_addr_s  = fa_r + 25'd1;
      pf_idx_s   = fi_r;

      case (state_r)
         IDLE: begin
            if (tgt_v_r) begin
               state_s    = ISSUE;
               fa_s       = tgt_addr_r;
               fi_s       = tgt_idx_r;
               mem_a_s    = tgt_map_s[24:2];
               mem_bank_s = tgt_map_s[1:0];
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (ce_ref) begin
               state_s = DATA;
               cnt_s   = 8'd0;
            end else begin
               state_s = ISSUE;
            end
         end
         DATA: begin
            if (ce_ref && (cnt_r == LAST_SLOT)) begin
               state_s = IDLE;
               cnt_s   = 8'd0;
               // A fetch that no longer matches the wanted address is dropped and relaunched.
               if (tgt_v_r && (fa_r == tgt_addr_r) && (fi_r == tgt_idx_r)) begin
                  buf_v_s   = 1'b1;
                  buf_tag_s = fa_r;
                  buf_idx_s = fi_r;
                  buf_dat_s = mem_dout;
                  tgt_v_s   = 1'b0;
                  if (pend_r) begin
                     din_s   = mem_dout;
                     wait_s  = 1'b0;
                     pend_s  = 1'b0;
                     pf_go_s = 1'b1;
                  end else begin
                     pend_s = 1'b0;
                  end
               end else begin
                  buf_v_s = buf_v_r;
               end
            end else if (ce_ref) begin
               cnt_s = cnt_r + 8'd1;
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: state_s = IDLE;
      endcase

      case ({rd_act_s, req_oor_s, hit_s})
         3'b110, 3'b111: din_s = 8'hFF;
         3'b101: begin
            din_s     = buf_dat_r;
            pf_go_s   = 1'b1;
            pf_addr_s = ioctl_addr + 25'd1;
            pf_idx_s  = ioctl_index;
         end
         3'b100: begin
            tgt_addr_s = ioctl_addr;
            tgt_idx_s  = ioctl_index;
            tgt_v_s    = 1'b1;
            pend_s     = 1'b1;
            wait_s     = 1'b1;
            pf_go_s    = 1'b0;
         end
         default: ;
      endcase

      pf_oor_s = addr_oor(pf_addr_s, pf_idx_s);

      // Session end overrides everything, including a latch in the same cycle.
      casez ({ioctl_upload, pf_go_s & PF_EN, pf_oor_s})
         3'b0??: begin
            state_s = IDLE;
            buf_v_s = 1'b0;
            wait_s  = 1'b0;
            pend_s  = 1'b0;
            tgt_v_s = 1'b0;
         end
         3'b111: begin
            buf_v_s   = 1'b1;
            buf_tag_s = pf_addr_s;
            buf_idx_s = pf_idx_s;
            buf_dat_s = 8'hFF;
            tgt_v_s   = 1'b0;
         end
         3'b110: begin
            tgt_addr_s = pf_addr_s;
            tgt_idx_s  = pf_idx_s;
            tgt_v_s    = 1'b1;
         end
         default: ;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         fa_r       <= 25'd0;
         fi_r       <= 8'd0;
         tgt_addr_r <= 25'd0;
         tgt_idx_r  <= 8'd0;
         tgt_v_r    <= 1'b0;
         pend_r     <= 1'b0;
         buf_tag_r  <= 25'd0;
         buf_idx_r  <= 8'd0;
         buf_dat_r  <= 8'hFF;
         buf_v_r    <= 1'b0;
         din_r      <= 8'hFF;
         wait_r     <= 1'b0;
         mem_a_r    <= 23'd0;
         mem_bank_r <= 2'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         fa_r       <= fa_s;
         fi_r       <= fi_s;
         tgt_addr_r <= tgt_addr_s;
         tgt_idx_r  <= tgt_idx_s;
         tgt_v_r    <= tgt_v_s;
         pend_r     <= pend_s;
         buf_tag_r  <= buf_tag_s;
         buf_idx_r  <= buf_idx_s;
         buf_dat_r  <= buf_dat_s;
         buf_v_r    <= buf_v_s;
         din_r      <= din_s;
         wait_r     <= wait_s;
         mem_a_r    <= mem_a_s;
         mem_bank_r <= mem_bank_s;
      end
   end

endmodule
